// File: rtl/cpu_pkg.sv
// ----------------------------------------------------------------------------
// cpu_pkg
//   Shared definitions for the CPU execute path: datapath width, ALU opcode
//   constants, the execute-controller state encoding and the flag pair
//   captured from the ALU.
// ----------------------------------------------------------------------------
package cpu_pkg;

   localparam int DATA_W = 32;

   localparam logic [3:0] OP_NOP = 4'h0;
   localparam logic [3:0] OP_ADD = 4'h1;
   localparam logic [3:0] OP_SUB = 4'h2;

   typedef enum logic [1:0] {
      EXS_IDLE = 2'd0,
      EXS_READ = 2'd1,
      EXS_EXEC = 2'd2,
      EXS_WB   = 2'd3
   } exs_state_t;

   typedef struct packed {
      logic n;
      logic z;
   } alu_flags_t;

   // Only ADD and SUB produce a result; every other encoding is a NOP.
   function automatic logic is_alu_op(input logic [3:0] op);
      return (op == OP_ADD) || (op == OP_SUB);
   endfunction

endpackage

// File: rtl/alu_exec_ctrl.sv
// ----------------------------------------------------------------------------
// alu_exec_ctrl
//   Multi-cycle execute controller between the decode stage and the register
//   file + ALU. One instruction is accepted over a valid/ready handshake and
//   walks IDLE -> READ -> EXEC -> WB, one cycle per state.
//
//   Ports
//     iClk, iRstN                 clock, asynchronous active-low reset
//     iInstValid / oInstReady     instruction handshake (ready only in IDLE)
//     iInstOp/Ra/Rb/Rc/SetF       decoded instruction fields
//     oRfRdAddrA/B, iRfRdDataA/B  register file read ports
//     oRfWrEn/Addr/Data           register file write port (one-cycle strobe)
//     oAluOp, oAluRegA/B          ALU drive (opcode is NOP outside EXEC)
//     iAluRegC, iAluNeg, iAluZero ALU result and flags (combinational)
//     oFlagN, oFlagZ              status flags
//     oDone                       one-cycle retire pulse
//
//   Parameters
//     REG_AW   register index width
//     R0_ZERO  1: writes to register 0 are dropped (R0 hardwired to zero)
// ----------------------------------------------------------------------------
module alu_exec_ctrl
   import cpu_pkg::*;
#(
   parameter int REG_AW  = 4,
   parameter bit R0_ZERO = 1'b1
) (
   input  logic              iClk,
   input  logic              iRstN,
   // decode side
   input  logic              iInstValid,
   output logic              oInstReady,
   input  logic [3:0]        iInstOp,
   input  logic [REG_AW-1:0] iInstRa,
   input  logic [REG_AW-1:0] iInstRb,
   input  logic [REG_AW-1:0] iInstRc,
   input  logic              iInstSetF,
   // register file
   output logic [REG_AW-1:0] oRfRdAddrA,
   output logic [REG_AW-1:0] oRfRdAddrB,
   input  logic [DATA_W-1:0] iRfRdDataA,
   input  logic [DATA_W-1:0] iRfRdDataB,
   output logic              oRfWrEn,
   output logic [REG_AW-1:0] oRfWrAddr,
   output logic [DATA_W-1:0] oRfWrData,
   // ALU
   output logic [3:0]        oAluOp,
   output logic [DATA_W-1:0] oAluRegA,
   output logic [DATA_W-1:0] oAluRegB,
   input  logic [DATA_W-1:0] iAluRegC,
   input  logic              iAluNeg,
   input  logic              iAluZero,
   // status
   output logic              oFlagN,
   output logic              oFlagZ,
   output logic              oDone
);

   exs_state_t        state;
   logic [3:0]        op_q;
   logic [REG_AW-1:0] rc_q;
   logic              setf_q;
   alu_flags_t        alu_flg_q;   // ALU flags captured at the end of EXEC
   alu_flags_t        flags;       // architectural status flags

   logic              wr_allowed;

   // A result is written only for real ALU ops, and never to R0 when it is
   // hardwired to zero.
   assign wr_allowed = is_alu_op(op_q) && !(R0_ZERO && (rc_q == '0));

   // -------------------------------------------------------------------------
   // Controller FSM. Every output is a register so the regfile and ALU see
   // clean, glitch-free drive.
   // -------------------------------------------------------------------------
   // NOTE: all sequential state uses non-blocking assignments so every
   // register samples its inputs as they were before the clock edge.
   always_ff @(posedge iClk or negedge iRstN) begin
      if (!iRstN) begin
         state      <= EXS_IDLE;
         oInstReady <= 1'b1;
         op_q       <= OP_NOP;
         rc_q       <= '0;
         setf_q     <= 1'b0;
         oRfRdAddrA <= '0;
         oRfRdAddrB <= '0;
         oAluOp     <= OP_NOP;
         oAluRegA   <= '0;
         oAluRegB   <= '0;
         alu_flg_q  <= '0;
         oRfWrEn    <= 1'b0;
         oRfWrAddr  <= '0;
         oRfWrData  <= '0;
         oDone      <= 1'b0;
      end else begin
         // Strobes default low; WB entry raises them for exactly one cycle.
         oRfWrEn <= 1'b0;
         oDone   <= 1'b0;

         case (state)
            EXS_IDLE: begin
               if (iInstValid) begin
                  op_q       <= iInstOp;
                  rc_q       <= iInstRc;
                  setf_q     <= iInstSetF;
                  // The read addresses double as the latched source indices
                  // and simply hold until the next accept.
                  oRfRdAddrA <= iInstRa;
                  oRfRdAddrB <= iInstRb;
                  oInstReady <= 1'b0;
                  state      <= EXS_READ;
               end
            end

            EXS_READ: begin
               // Regfile data for the addresses presented in READ is sampled
               // on entry to EXEC.
               oAluRegA <= iRfRdDataA;
               oAluRegB <= iRfRdDataB;
               // Unknown opcodes are driven as NOP so the ALU only ever sees
               // ADD, SUB or NOP.
               oAluOp   <= is_alu_op(op_q) ? op_q : OP_NOP;
               state    <= EXS_EXEC;
            end

            EXS_EXEC: begin
               alu_flg_q <= '{n: iAluNeg, z: iAluZero};
               oRfWrData <= iAluRegC;
               oRfWrAddr <= rc_q;
               oRfWrEn   <= wr_allowed;
               oDone     <= 1'b1;
               oAluOp    <= OP_NOP;
               state     <= EXS_WB;
            end

            EXS_WB: begin
               oInstReady <= 1'b1;
               state      <= EXS_IDLE;
            end
         endcase
      end
   end

   // -------------------------------------------------------------------------
   // Status flags: committed at the end of WB from the values captured at the
   // end of EXEC. NOPs leave them untouched even with SetF; a write dropped
   // for R0 still updates them.
   // -------------------------------------------------------------------------
   always_ff @(posedge iClk or negedge iRstN) begin
      if (!iRstN) begin
         flags <= '0;
      end else if ((state == EXS_WB) && setf_q && is_alu_op(op_q)) begin
         flags <= alu_flg_q;
      end
   end

   assign oFlagN = flags.n;
   assign oFlagZ = flags.z;

endmodule

// File: tb/tb_alu_exec_ctrl.sv
// ----------------------------------------------------------------------------
// tb_alu_exec_ctrl
//   Self-checking bench for alu_exec_ctrl. Supplies a combinational ALU and a
//   register file, drives directed and randomized instructions, and compares
//   each phase against an instruction-level reference model (register array
//   plus N/Z flags).
// ----------------------------------------------------------------------------
module tb_alu_exec_ctrl;
   import cpu_pkg::*;

   localparam int AW = 4;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   always #5 clk = ~clk;

   logic          inst_valid = 1'b0;
   logic          inst_ready;
   logic [3:0]    inst_op = '0;
   logic [AW-1:0] inst_ra = '0, inst_rb = '0, inst_rc = '0;
   logic          inst_setf = 1'b0;
   logic [AW-1:0] rd_addr_a, rd_addr_b;
   logic [31:0]   rd_data_a, rd_data_b;
   logic          wr_en;
   logic [AW-1:0] wr_addr;
   logic [31:0]   wr_data;
   logic [3:0]    alu_op;
   logic [31:0]   alu_a, alu_b, alu_c;
   logic          alu_neg, alu_zero;
   logic          flag_n, flag_z, done;

   // bench-side register file and reference model
   logic [31:0]   rf [16];
   logic [31:0]   model_regs [16];
   logic          model_n = 1'b0, model_z = 1'b0;

   int            n_checks = 0;
   int            n_fail = 0;

   alu_exec_ctrl #(.REG_AW(AW), .R0_ZERO(1'b1)) dut (
      .iClk(clk), .iRstN(rst_n),
      .iInstValid(inst_valid), .oInstReady(inst_ready),
      .iInstOp(inst_op), .iInstRa(inst_ra), .iInstRb(inst_rb), .iInstRc(inst_rc),
      .iInstSetF(inst_setf),
      .oRfRdAddrA(rd_addr_a), .oRfRdAddrB(rd_addr_b),
      .iRfRdDataA(rd_data_a), .iRfRdDataB(rd_data_b),
      .oRfWrEn(wr_en), .oRfWrAddr(wr_addr), .oRfWrData(wr_data),
      .oAluOp(alu_op), .oAluRegA(alu_a), .oAluRegB(alu_b),
      .iAluRegC(alu_c), .iAluNeg(alu_neg), .iAluZero(alu_zero),
      .oFlagN(flag_n), .oFlagZ(flag_z), .oDone(done)
   );

   // external ALU
   always_comb begin
      alu_c = 32'd0;
      if (alu_op == 4'h1) alu_c = alu_a + alu_b;
      else if (alu_op == 4'h2) alu_c = alu_a - alu_b;
   end
   assign alu_neg  = alu_c[31];
   assign alu_zero = (alu_c == 32'd0);

   // external register file
   assign rd_data_a = rf[rd_addr_a];
   assign rd_data_b = rf[rd_addr_b];
   always @(posedge clk) if (wr_en) rf[wr_addr] <= wr_data;

   task automatic preload(input int idx, input logic [31:0] v);
      rf[idx] = v;
      model_regs[idx] = v;
   endtask

   // Issue one instruction and check every phase against the model.
   task automatic run_instr(input logic [3:0] op, input logic [AW-1:0] a_i,
                            input logic [AW-1:0] b_i, input logic [AW-1:0] c_i,
                            input logic sf, input string tag);
      logic [31:0] va, vb, res;
      logic        alu_ok, exp_wr;
      logic [3:0]  exp_op;
      int          waited;
      va     = model_regs[a_i];
      vb     = model_regs[b_i];
      alu_ok = (op == 4'h1) || (op == 4'h2);
      res    = (op == 4'h1) ? va + vb : (op == 4'h2) ? va - vb : 32'd0;
      exp_wr = alu_ok && (c_i != 0);
      exp_op = alu_ok ? op : 4'h0;

      waited = 0;
      while (!inst_ready && waited < 10) begin @(negedge clk); waited++; end
      n_checks++;
      if (inst_ready !== 1'b1) begin
         n_fail++; $display("FAIL %s ready_timeout got=%b exp=1", tag, inst_ready);
         return;
      end
      inst_valid = 1'b1; inst_op = op; inst_ra = a_i; inst_rb = b_i;
      inst_rc = c_i; inst_setf = sf;
      @(negedge clk);  // READ
      inst_valid = 1'b0;
      n_checks++; if (inst_ready !== 1'b0) begin n_fail++; $display("FAIL %s read_ready got=%b exp=0", tag, inst_ready); end
      n_checks++; if (rd_addr_a !== a_i) begin n_fail++; $display("FAIL %s rd_addr_a got=%0d exp=%0d", tag, rd_addr_a, a_i); end
      n_checks++; if (rd_addr_b !== b_i) begin n_fail++; $display("FAIL %s rd_addr_b got=%0d exp=%0d", tag, rd_addr_b, b_i); end
      n_checks++; if (alu_op !== 4'h0) begin n_fail++; $display("FAIL %s read_alu_op got=%h exp=0", tag, alu_op); end
      n_checks++; if ({wr_en, done} !== 2'b00) begin n_fail++; $display("FAIL %s read_strobes got=%b exp=00", tag, {wr_en, done}); end
      @(negedge clk);  // EXEC
      n_checks++; if (alu_op !== exp_op) begin n_fail++; $display("FAIL %s exec_alu_op got=%h exp=%h", tag, alu_op, exp_op); end
      n_checks++; if (alu_a !== va) begin n_fail++; $display("FAIL %s alu_a got=%h exp=%h", tag, alu_a, va); end
      n_checks++; if (alu_b !== vb) begin n_fail++; $display("FAIL %s alu_b got=%h exp=%h", tag, alu_b, vb); end
      n_checks++; if ({wr_en, done, inst_ready} !== 3'b000) begin n_fail++; $display("FAIL %s exec_strobes got=%b exp=000", tag, {wr_en, done, inst_ready}); end
      @(negedge clk);  // WB
      n_checks++; if (wr_en !== exp_wr) begin n_fail++; $display("FAIL %s wr_en got=%b exp=%b", tag, wr_en, exp_wr); end
      n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL %s done got=%b exp=1", tag, done); end
      n_checks++; if (alu_op !== 4'h0) begin n_fail++; $display("FAIL %s wb_alu_op got=%h exp=0", tag, alu_op); end
      if (exp_wr) begin
         n_checks++; if (wr_addr !== c_i) begin n_fail++; $display("FAIL %s wr_addr got=%0d exp=%0d", tag, wr_addr, c_i); end
         n_checks++; if (wr_data !== res) begin n_fail++; $display("FAIL %s wr_data got=%h exp=%h", tag, wr_data, res); end
      end
      if (exp_wr) model_regs[c_i] = res;
      if (alu_ok && sf) begin model_n = res[31]; model_z = (res == 32'd0); end
      @(negedge clk);  // back in IDLE
      n_checks++; if (inst_ready !== 1'b1) begin n_fail++; $display("FAIL %s idle_ready got=%b exp=1", tag, inst_ready); end
      n_checks++; if ({wr_en, done} !== 2'b00) begin n_fail++; $display("FAIL %s idle_strobes got=%b exp=00", tag, {wr_en, done}); end
      n_checks++; if (flag_n !== model_n) begin n_fail++; $display("FAIL %s flag_n got=%b exp=%b", tag, flag_n, model_n); end
      n_checks++; if (flag_z !== model_z) begin n_fail++; $display("FAIL %s flag_z got=%b exp=%b", tag, flag_z, model_z); end
      n_checks++; if (rf[c_i] !== model_regs[c_i]) begin n_fail++; $display("FAIL %s rf_dest got=%h exp=%h", tag, rf[c_i], model_regs[c_i]); end
   endtask

   task automatic test_reset();
      for (int i = 0; i < 16; i++) preload(i, 32'd0);
      @(negedge clk);
      n_checks++; if (inst_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got=%b exp=1", inst_ready); end
      n_checks++; if ({wr_en, done, flag_n, flag_z} !== 4'b0000) begin n_fail++; $display("FAIL reset_bits got=%b exp=0000", {wr_en, done, flag_n, flag_z}); end
      n_checks++; if (alu_op !== 4'h0) begin n_fail++; $display("FAIL reset_alu_op got=%h exp=0", alu_op); end
      n_checks++; if ({rd_addr_a, rd_addr_b, wr_addr} !== '0) begin n_fail++; $display("FAIL reset_addrs got=%h exp=0", {rd_addr_a, rd_addr_b, wr_addr}); end
      n_checks++; if ({alu_a, alu_b, wr_data} !== '0) begin n_fail++; $display("FAIL reset_data got=%h exp=0", {alu_a, alu_b, wr_data}); end
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_add();
      preload(1, 32'd5); preload(2, 32'd7);
      run_instr(4'h1, 4'd1, 4'd2, 4'd3, 1'b1, "add");
   endtask

   task automatic test_sub_zero();
      preload(1, 32'd9); preload(2, 32'd9);
      run_instr(4'h2, 4'd1, 4'd2, 4'd5, 1'b1, "sub_zero");
      run_instr(4'h1, 4'd1, 4'd2, 4'd6, 1'b0, "add_nosetf");
   endtask

   task automatic test_wrap();
      preload(7, 32'd3); preload(8, 32'd4);
      run_instr(4'h2, 4'd7, 4'd8, 4'd9, 1'b1, "sub_neg");
      preload(10, 32'hFFFF_FFFF); preload(11, 32'd1);
      run_instr(4'h1, 4'd10, 4'd11, 4'd12, 1'b1, "add_wrap");
   endtask

   task automatic test_nop();
      run_instr(4'h7, 4'd1, 4'd2, 4'd13, 1'b1, "nop7");
   endtask

   task automatic test_r0();
      preload(1, 32'd1);
      run_instr(4'h1, 4'd1, 4'd1, 4'd0, 1'b1, "r0_dest");
   endtask

   task automatic test_random();
      for (int i = 1; i < 16; i++) preload(i, $urandom);
      for (int n = 0; n < 40; n++)
         run_instr(4'($urandom_range(0, 3)), 4'($urandom_range(0, 15)),
                   4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                   1'($urandom_range(0, 1)), "random");
   endtask

   // Valid held high: R4 = R4 + R4 three times, one accept every 4 cycles.
   task automatic test_back_to_back();
      logic [31:0] exp_d;
      preload(4, 32'd3);
      inst_op = 4'h1; inst_ra = 4'd4; inst_rb = 4'd4; inst_rc = 4'd4; inst_setf = 1'b1;
      inst_valid = 1'b1;
      for (int c = 0; c < 12; c++) begin
         n_checks++; if (inst_ready !== (c % 4 == 0)) begin n_fail++; $display("FAIL b2b_ready cycle=%0d got=%b", c, inst_ready); end
         n_checks++; if (done !== (c % 4 == 3)) begin n_fail++; $display("FAIL b2b_done cycle=%0d got=%b", c, done); end
         if (c % 4 == 3) begin
            exp_d = 32'd3 << (c / 4 + 1);
            n_checks++; if (wr_data !== exp_d) begin n_fail++; $display("FAIL b2b_data cycle=%0d got=%h exp=%h", c, wr_data, exp_d); end
         end
         @(negedge clk);
      end
      inst_valid = 1'b0;
      model_regs[4] = 32'd24; model_n = 1'b0; model_z = 1'b0;
      n_checks++; if (rf[4] !== 32'd24) begin n_fail++; $display("FAIL b2b_rf got=%h exp=18", rf[4]); end
      n_checks++; if ({flag_n, flag_z} !== 2'b00) begin n_fail++; $display("FAIL b2b_flags got=%b exp=00", {flag_n, flag_z}); end
      @(negedge clk);
   endtask

   task automatic test_reset_mid();
      preload(1, 32'd100); preload(2, 32'd50); preload(14, 32'h1234);
      run_instr(4'h2, 4'd2, 4'd1, 4'd3, 1'b1, "pre_reset_neg");
      inst_valid = 1'b1; inst_op = 4'h1; inst_ra = 4'd1; inst_rb = 4'd2;
      inst_rc = 4'd14; inst_setf = 1'b1;
      @(negedge clk);  // READ
      inst_valid = 1'b0;
      @(negedge clk);  // EXEC
      rst_n = 1'b0;
      #1;
      model_n = 1'b0; model_z = 1'b0;
      n_checks++; if (inst_ready !== 1'b1) begin n_fail++; $display("FAIL rst_mid_ready got=%b exp=1", inst_ready); end
      n_checks++; if ({flag_n, flag_z} !== 2'b00) begin n_fail++; $display("FAIL rst_mid_flags got=%b exp=00", {flag_n, flag_z}); end
      n_checks++; if (alu_op !== 4'h0) begin n_fail++; $display("FAIL rst_mid_alu_op got=%h exp=0", alu_op); end
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         n_checks++; if ({wr_en, done} !== 2'b00) begin n_fail++; $display("FAIL rst_mid_strobes cycle=%0d got=%b exp=00", c, {wr_en, done}); end
      end
      rst_n = 1'b1;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         n_checks++; if ({wr_en, done} !== 2'b00) begin n_fail++; $display("FAIL rst_rel_strobes cycle=%0d got=%b exp=00", c, {wr_en, done}); end
      end
      n_checks++; if (inst_ready !== 1'b1) begin n_fail++; $display("FAIL rst_rel_ready got=%b exp=1", inst_ready); end
      n_checks++; if (rf[14] !== 32'h1234) begin n_fail++; $display("FAIL rst_no_write got=%h exp=1234", rf[14]); end
      run_instr(4'h1, 4'd1, 4'd2, 4'd14, 1'b1, "post_reset_add");
   endtask

   initial begin
      test_reset();
      test_add();
      test_sub_zero();
      test_wrap();
      test_nop();
      test_r0();
      test_random();
      test_back_to_back();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired checks=%0d", n_checks);
      $fatal(1, "watchdog");
   end

endmodule
